// File: rtl/bcd_count_display_if.sv
// ---------------------------------------------------------------------------
// bcd_count_display_if
//   Bundles the trigger-pulse inputs and the display/status outputs of the
//   BCD count-and-display block.
//
//   master modport : drives inc_clk, ref_clk, digit_sel, clear;
//                    observes disp_bcd, seg, digit_en, busy, overflow
//   slave  modport : the counter/display block itself
//
//   inc_clk    one-cycle increment pulse
//   ref_clk    one-cycle refresh pulse (display latch request)
//   digit_sel  per-digit add mask, bit i adds 1 to digit i
//   clear      synchronous clear of counter and overflow
//   disp_bcd   latched display value, digit i at [4i+3:4i]
//   seg        7-segment pattern {g,f,e,d,c,b,a}, active-high
//   digit_en   one-hot digit enable, active-high
//   busy       carry ripple in progress
//   overflow   sticky carry out of the top digit
// ---------------------------------------------------------------------------
interface bcd_count_display_if #(
  parameter int DIGITS = 6
);
  logic                  inc_clk;
  logic                  ref_clk;
  logic [DIGITS-1:0]     digit_sel;
  logic                  clear;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     digit_en;
  logic                  busy;
  logic                  overflow;

  modport master (
    output inc_clk, ref_clk, digit_sel, clear,
    input  disp_bcd, seg, digit_en, busy, overflow
  );

  modport slave (
    input  inc_clk, ref_clk, digit_sel, clear,
    output disp_bcd, seg, digit_en, busy, overflow
  );
endinterface

// File: rtl/bcd_count_display.sv
// ---------------------------------------------------------------------------
// bcd_count_display
//   Multi-digit decimal counter fed by increment/refresh pulses. An increment
//   adds a per-digit mask to the count, rippling the carry one digit per
//   clock; a refresh latches the count into the display register, which is
//   scanned out onto a time-multiplexed 7-segment display.
//
//   Parameters
//     DIGITS    number of BCD digits (1..16)
//     SCAN_DIV  log2 of clock cycles each digit stays enabled while scanning
//
//   Ports
//     clk    system clock
//     rst_n  synchronous reset, active-low
//     bus    slave side of bcd_count_display_if (pulses in, display out)
// ---------------------------------------------------------------------------
module bcd_count_display #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_count_display_if.slave    bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {
    IDLE,
    RIPPLE
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state_reg;
  logic [4*DIGITS-1:0]   cnt_reg;
  logic [4*DIGITS-1:0]   disp_reg;
  logic [DIGITS-1:0]     pend_reg;
  logic                  carry_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  ref_pend_reg;
  logic                  busy_reg;
  logic                  overflow_reg;
  logic [SCAN_DIV-1:0]   presc_reg;
  logic [IDX_W-1:0]      scan_reg;
  logic [6:0]            seg_reg;
  logic [DIGITS-1:0]     digit_en_reg;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [3:0]            cnt_dig [DIGITS];
  logic [3:0]            disp_next_dig [DIGITS];
  logic [4*DIGITS-1:0]   cnt_ripple;
  logic [4*DIGITS-1:0]   disp_next;
  logic [3:0]            cur_digit;
  logic [4:0]            sum;
  logic [3:0]            new_digit;
  logic                  carry_next;
  logic                  last_digit;
  logic [SCAN_DIV-1:0]   presc_next;
  logic [IDX_W-1:0]      scan_next;
  logic [6:0]            seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;   // non-BCD codes blank the digit
    endcase
    return s;
  endfunction

  // Per-digit views of the counter and of the next display value, and the
  // counter with only the digit under the ripple pointer replaced.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign cnt_dig[gi]             = cnt_reg[4*gi +: 4];
      assign disp_next_dig[gi]       = disp_next[4*gi +: 4];
      assign cnt_ripple[4*gi +: 4]   = (idx_reg == IDX_W'(gi)) ? new_digit : cnt_dig[gi];
    end
  endgenerate

  // One ripple step: digit + mask bit + incoming carry never exceeds 11,
  // so a single subtract-10 correction is enough.
  always_comb begin
    cur_digit  = cnt_dig[idx_reg];
    sum        = 5'(cur_digit) + 5'(pend_reg[idx_reg]) + 5'(carry_reg);
    new_digit  = sum[3:0];
    carry_next = 1'b0;
    if (sum >= 5'd10) begin
      new_digit  = 4'(sum - 5'd10);
      carry_next = 1'b1;
    end
    last_digit = (idx_reg == LAST_IDX);
  end

  // Display latch. A refresh seen during the ripple (held in ref_pend_reg,
  // or arriving on the final step) captures the post-ripple count on the
  // same edge that drops busy, so the display never shows a half-carried
  // value. clear blocks the refresh and leaves the display untouched.
  always_comb begin
    disp_next = disp_reg;
    if (!bus.clear) begin
      if (state_reg == IDLE && bus.ref_clk) begin
        disp_next = cnt_reg;
      end else if (state_reg == RIPPLE && last_digit && (ref_pend_reg || bus.ref_clk)) begin
        disp_next = cnt_ripple;
      end
    end
  end

  // Scan timing. seg and digit_en are both derived from next-state values
  // so the pattern and its enable always change on the same edge.
  always_comb begin
    presc_next = presc_reg + SCAN_DIV'(1);
    scan_next  = scan_reg;
    if (presc_reg == '1) begin
      scan_next = (scan_reg == LAST_IDX) ? '0 : scan_reg + IDX_W'(1);
    end
    seg_next = seg_decode(disp_next_dig[scan_next]);
  end

  // -------------------------------------------------------------------------
  // Sequential logic: counter FSM, display latch and scan registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      disp_reg     <= '0;
      pend_reg     <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      ref_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      presc_reg    <= '0;
      scan_reg     <= '0;
      seg_reg      <= 7'h3F;
      digit_en_reg <= DIGITS'(1);
    end else begin
      presc_reg    <= presc_next;
      scan_reg     <= scan_next;
      disp_reg     <= disp_next;
      seg_reg      <= seg_next;
      digit_en_reg <= DIGITS'(1) << scan_next;

      if (bus.clear) begin
        state_reg    <= IDLE;
        cnt_reg      <= '0;
        pend_reg     <= '0;
        carry_reg    <= 1'b0;
        idx_reg      <= '0;
        ref_pend_reg <= 1'b0;
        busy_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.inc_clk) begin
              pend_reg  <= bus.digit_sel;
              carry_reg <= 1'b0;
              idx_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= RIPPLE;
            end
          end

          RIPPLE: begin
            // inc_clk is deliberately not looked at here: increments that
            // arrive mid-ripple are dropped.
            cnt_reg   <= cnt_ripple;
            carry_reg <= carry_next;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (bus.ref_clk) begin
              ref_pend_reg <= 1'b1;
            end
            if (last_digit) begin
              if (carry_next) begin
                overflow_reg <= 1'b1;
              end
              ref_pend_reg <= 1'b0;
              idx_reg      <= '0;
              carry_reg    <= 1'b0;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.disp_bcd = disp_reg;
  assign bus.seg      = seg_reg;
  assign bus.digit_en = digit_en_reg;
  assign bus.busy     = busy_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_count_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_display
//   Self-checking bench for bcd_count_display (DIGITS=6, SCAN_DIV=2).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   A decimal model tracks the count; refresh requests push the expected
//   display value into a scoreboard queue that is popped when the display
//   is checked.
// ---------------------------------------------------------------------------
module tb_bcd_count_display;
  localparam int DIGITS   = 6;
  localparam int SCAN_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_count_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_count_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sel;
    logic [23:0] exp_disp;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs [6];
  logic [23:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      model_val = 0;
  logic        model_ovf = 1'b0;
  logic [23:0] disp_exp = '0;
  logic [6:0]  pats [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [23:0] to_bcd(input longint v);
    logic [23:0] r;
    longint t;
    t = v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model_inc(input logic [5:0] sel);
    longint add;
    longint p;
    add = 0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (sel[i]) add += p;
      p *= 10;
    end
    model_val += add;
    if (model_val >= 1000000) begin
      model_val -= 1000000;
      model_ovf = 1'b1;
    end
  endfunction

  task automatic pulse_inc(input logic [5:0] sel);
    bus.digit_sel = sel;
    bus.inc_clk   = 1'b1;
    @(negedge clk);
    bus.inc_clk   = 1'b0;
    bus.digit_sel = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_inc(input logic [5:0] sel);
    int cyc;
    pulse_inc(sel);
    model_inc(sel);
    wait_idle(cyc);
    check("busy_len", cyc, 6);
  endtask

  task automatic do_ref(input logic [23:0] exp);
    logic [23:0] e;
    sb_q.push_back(exp);
    bus.ref_clk = 1'b1;
    @(negedge clk);
    bus.ref_clk = 1'b0;
    e = sb_q.pop_front();
    check("disp_ref", bus.disp_bcd, e);
    disp_exp = e;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_val = 0;
    model_ovf = 1'b0;
  endtask

  initial begin
    int cyc;
    int wd;
    logic [23:0] e;

    bus.inc_clk   = 1'b0;
    bus.ref_clk   = 1'b0;
    bus.clear     = 1'b0;
    bus.digit_sel = '0;

    vecs[0] = '{sel: 6'b000001, exp_disp: 24'h000001, exp_ovf: 1'b0};
    vecs[1] = '{sel: 6'b000011, exp_disp: 24'h000012, exp_ovf: 1'b0};
    vecs[2] = '{sel: 6'b111111, exp_disp: 24'h111123, exp_ovf: 1'b0};
    vecs[3] = '{sel: 6'b100000, exp_disp: 24'h211123, exp_ovf: 1'b0};
    vecs[4] = '{sel: 6'b000111, exp_disp: 24'h211234, exp_ovf: 1'b0};
    vecs[5] = '{sel: 6'b001000, exp_disp: 24'h212234, exp_ovf: 1'b0};

    pats[0] = 7'h7D;  // digit0 = 6
    pats[1] = 7'h6D;  // digit1 = 5
    pats[2] = 7'h66;  // digit2 = 4
    pats[3] = 7'h4F;  // digit3 = 3
    pats[4] = 7'h5B;  // digit4 = 2
    pats[5] = 7'h06;  // digit5 = 1

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_disp", bus.disp_bcd, 24'h0);
    check("rst_seg", bus.seg, 7'h3F);
    check("rst_digit_en", bus.digit_en, 6'b000001);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven increments, each followed by a refresh
    for (int i = 0; i < 6; i++) begin
      do_inc(vecs[i].sel);
      check("disp_hold", bus.disp_bcd, disp_exp);
      do_ref(vecs[i].exp_disp);
      check("ovf_vec", bus.overflow, vecs[i].exp_ovf);
    end

    // clear mid-ripple, with a second (dropped) inc in flight
    pulse_inc(6'b000001);
    @(negedge clk);
    pulse_inc(6'b111111);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_val = 0;
    model_ovf = 1'b0;
    check("clr_busy", bus.busy, 1'b0);
    check("clr_disp_kept", bus.disp_bcd, disp_exp);
    check("clr_ovf", bus.overflow, 1'b0);
    do_ref(to_bcd(model_val));

    // inc during ripple is dropped
    pulse_inc(6'b000001);
    model_inc(6'b000001);
    @(negedge clk);
    pulse_inc(6'b111111);
    wait_idle(cyc);
    check("busy_len_drop", cyc, 4);
    do_ref(to_bcd(model_val));

    // carry across digit 0: 9 + 1, then 0 + 1 + carry
    do_clear();
    repeat (9) do_inc(6'b000001);
    do_inc(6'b000011);
    do_ref(to_bcd(model_val));
    check("carry_ovf", bus.overflow, model_ovf);

    // refresh 2 cycles after inc: display follows busy falling
    pulse_inc(6'b000001);
    model_inc(6'b000001);
    @(negedge clk);
    bus.ref_clk = 1'b1;
    sb_q.push_back(to_bcd(model_val));
    @(negedge clk);
    bus.ref_clk = 1'b0;
    check("disp_mid_ripple", bus.disp_bcd, disp_exp);
    wait_idle(cyc);
    check("busy_len_ref", cyc, 4);
    e = sb_q.pop_front();
    check("disp_at_fall", bus.disp_bcd, e);
    disp_exp = e;

    // inc and ref in the same idle cycle: pre-increment value is latched
    bus.ref_clk = 1'b1;
    pulse_inc(6'b000001);
    bus.ref_clk = 1'b0;
    check("disp_pre_inc", bus.disp_bcd, disp_exp);
    model_inc(6'b000001);
    wait_idle(cyc);
    check("busy_len_same", cyc, 6);
    check("disp_still_pre", bus.disp_bcd, disp_exp);
    do_ref(to_bcd(model_val));

    // wrap: 999999 + 1
    do_clear();
    repeat (9) do_inc(6'b111111);
    do_ref(to_bcd(model_val));
    check("ovf_before_wrap", bus.overflow, model_ovf);
    do_inc(6'b000001);
    do_ref(to_bcd(model_val));
    check("ovf_wrap", bus.overflow, model_ovf);
    @(negedge clk);
    check("ovf_sticky", bus.overflow, model_ovf);
    do_clear();
    check("ovf_cleared", bus.overflow, model_ovf);

    // build 123456 and watch the scan
    do_inc(6'b111111);
    do_inc(6'b011111);
    do_inc(6'b001111);
    do_inc(6'b000111);
    do_inc(6'b000011);
    do_inc(6'b000001);
    do_ref(to_bcd(model_val));
    wd = 0;
    while (bus.digit_en !== 6'b100000 && wd < 200) begin
      wd++;
      @(negedge clk);
    end
    check("scan_sync_hi", bus.digit_en, 6'b100000);
    wd = 0;
    while (bus.digit_en !== 6'b000001 && wd < 200) begin
      wd++;
      @(negedge clk);
    end
    check("scan_sync_lo", bus.digit_en, 6'b000001);
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 4; c++) begin
        check("scan_en", bus.digit_en, 32'(6'b000001 << (k % 6)));
        check("scan_seg", bus.seg, pats[k % 6]);
        @(negedge clk);
      end
    end

    // reset in the middle of a ripple
    pulse_inc(6'b000001);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_busy", bus.busy, 1'b0);
    check("rst2_disp", bus.disp_bcd, 24'h0);
    check("rst2_ovf", bus.overflow, 1'b0);
    check("rst2_seg", bus.seg, 7'h3F);
    check("rst2_digit_en", bus.digit_en, 6'b000001);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
